// File: rtl/dmem_arbiter_pkg.sv
// Shared codes and state encoding for the data-memory arbiter and its validator.
package dmem_arbiter_pkg;

    localparam logic [2:0] MEMREAD_NONE  = 3'd0;
    localparam logic [2:0] MEMREAD_LB    = 3'd1;
    localparam logic [2:0] MEMREAD_LH    = 3'd2;
    localparam logic [2:0] MEMREAD_LW    = 3'd3;
    localparam logic [2:0] MEMREAD_LBU   = 3'd4;
    localparam logic [2:0] MEMREAD_LHU   = 3'd5;

    localparam logic [1:0] MEMWRITE_NONE = 2'd0;
    localparam logic [1:0] MEMWRITE_SB   = 2'd1;
    localparam logic [1:0] MEMWRITE_SH   = 2'd2;
    localparam logic [1:0] MEMWRITE_SW   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Bytes touched by a load code; 0 marks NONE or an undefined code.
    function automatic logic [2:0] read_size(input logic [2:0] code);
        case (code)
            MEMREAD_LB, MEMREAD_LBU: read_size = 3'd1;
            MEMREAD_LH, MEMREAD_LHU: read_size = 3'd2;
            MEMREAD_LW:              read_size = 3'd4;
            default:                 read_size = 3'd0;
        endcase
    endfunction

    // Bytes touched by a store code; 0 marks NONE.
    function automatic logic [2:0] write_size(input logic [1:0] code);
        case (code)
            MEMWRITE_SB: write_size = 3'd1;
            MEMWRITE_SH: write_size = 3'd2;
            MEMWRITE_SW: write_size = 3'd4;
            default:     write_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational request validator: flags bad code combinations, misalignment
// and accesses whose last byte falls outside the 2**ADDR_W byte memory.
module dmem_req_check
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [2:0]  read_i,
    input  logic [1:0]  write_i,
    input  logic [31:0] addr_i,
    output logic        err_o
);

    logic [2:0]  size_s;
    logic [32:0] last_s;
    logic        code_err_s;
    logic        align_err_s;
    logic        range_err_s;

    // Exactly one defined code gives a non-zero size; every other combination is a code error.
    always_comb begin
        size_s = 3'd0;
        if ((read_i != MEMREAD_NONE) && (write_i == MEMWRITE_NONE)) begin
            size_s = read_size(read_i);
        end else if ((read_i == MEMREAD_NONE) && (write_i != MEMWRITE_NONE)) begin
            size_s = write_size(write_i);
        end else begin
            size_s = 3'd0;
        end
        code_err_s = (size_s == 3'd0);
    end

    // Alignment and upper-bound checks on the resolved size; 33-bit sum keeps the carry.
    always_comb begin
        case (size_s)
            3'd2:    align_err_s = addr_i[0];
            3'd4:    align_err_s = |addr_i[1:0];
            default: align_err_s = 1'b0;
        endcase
        last_s      = {1'b0, addr_i} + {30'd0, size_s} - 33'd1;
        range_err_s = ((last_s >> ADDR_W) != 33'd0);
        err_o       = code_err_s | align_err_s | range_err_s;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter that sequences one data-memory access per
// granted request and returns the result to the requesting port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_read,
    input  logic [1:0]  p0_write,
    output logic        p0_resp_valid,
    output logic [31:0] p0_rdata,
    output logic        p0_resp_err,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_read,
    input  logic [1:0]  p1_write,
    output logic        p1_resp_valid,
    output logic [31:0] p1_rdata,
    output logic        p1_resp_err,
    output logic [2:0]  mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              last_q, last_d;        // port granted most recently
    logic              port_q, port_d;        // port owning the in-flight request
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        read_q, read_d;
    logic [1:0]        write_q, write_d;
    logic              err_q, err_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [1:0][31:0]  rdata_q, rdata_d;

    logic              grant_s;
    logic              accept_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic [2:0]        sel_read_s;
    logic [1:0]        sel_write_s;
    logic              chk_err_s;

    dmem_req_check #(
        .ADDR_W (ADDR_W)
    ) u_req_check (
        .read_i  (sel_read_s),
        .write_i (sel_write_s),
        .addr_i  (sel_addr_s),
        .err_o   (chk_err_s)
    );

    // Pick the winner: a lone valid port wins, a tie goes to the port not served last.
    always_comb begin
        if (p0_req_valid && p1_req_valid) begin
            grant_s = ~last_q;
        end else if (p1_req_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s     = rst_n && ((state_q == IDLE) || (state_q == RESP)) &&
                       (p0_req_valid || p1_req_valid);
        p0_req_ready = accept_s && !grant_s;
        p1_req_ready = accept_s && grant_s;
        sel_addr_s   = grant_s ? p1_addr  : p0_addr;
        sel_wdata_s  = grant_s ? p1_wdata : p0_wdata;
        sel_read_s   = grant_s ? p1_read  : p0_read;
        sel_write_s  = grant_s ? p1_write : p0_write;
    end

    // Next-state logic: latch on acceptance, capture read data at the end of ACCESS.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        port_d       = port_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        read_d       = read_q;
        write_d      = write_q;
        err_d        = err_q;
        resp_valid_d = 2'b00;
        resp_err_d   = 2'b00;
        rdata_d      = '0;
        case (state_q)
            IDLE:    state_d = accept_s ? ACCESS : IDLE;
            ACCESS: begin
                state_d              = RESP;
                resp_valid_d[port_q] = 1'b1;
                resp_err_d[port_q]   = err_q;
                rdata_d[port_q]      = (read_q != MEMREAD_NONE) ? mem_rdata : 32'd0;
            end
            RESP:    state_d = accept_s ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept_s) begin
            last_d  = grant_s;
            port_d  = grant_s;
            addr_d  = sel_addr_s;
            wdata_d = sel_wdata_s;
            err_d   = chk_err_s;
            // A rejected request still walks through ACCESS, but touches nothing.
            read_d  = chk_err_s ? MEMREAD_NONE  : sel_read_s;
            write_d = chk_err_s ? MEMWRITE_NONE : sel_write_s;
        end else begin
            last_d  = last_q;
        end
    end

    // State and request registers; reset favours port 0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            port_q       <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            read_q       <= MEMREAD_NONE;
            write_q      <= MEMWRITE_NONE;
            err_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 2'b00;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory bus is live only in ACCESS; reset kills a write before the memory's negedge.
    always_comb begin
        if ((state_q == ACCESS) && rst_n) begin
            mem_read  = read_q;
            mem_write = write_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end else begin
            mem_read  = MEMREAD_NONE;
            mem_write = MEMWRITE_NONE;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
        end
    end

    assign p0_resp_valid = resp_valid_q[0];
    assign p1_resp_valid = resp_valid_q[1];
    assign p0_resp_err   = resp_err_q[0];
    assign p1_resp_err   = resp_err_q[1];
    assign p0_rdata      = rdata_q[0];
    assign p1_rdata      = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: little-endian byte memory on the memory side, and a
// transaction-level reference (grant rule, validity rule, shadow memory).
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid_s = 2'b00;
    logic [31:0] addr_s [2];
    logic [31:0] wdata_s [2];
    logic [2:0]  rd_s [2];
    logic [1:0]  wr_s [2];
    logic [1:0]  rdy_s, rv_s, rerr_s;
    logic [31:0] rdat_s [2];
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] ma;

    bit [7:0] dmem    [0:65535];
    bit [7:0] ref_mem [0:65535];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state, transaction level
    int          last_grant = 1;
    bit          acc_pend = 1'b0, resp_pend = 1'b0;
    int          acc_port = 0, resp_port = 0;
    logic [2:0]  acc_rd;
    logic [1:0]  acc_wr;
    logic [31:0] acc_addr, acc_wdata, resp_rdata;
    bit          acc_err, resp_err;
    logic [31:0] obs_rdata [2];
    logic        obs_err [2];
    int          obs_grants [$];

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(valid_s[0]), .p0_req_ready(rdy_s[0]), .p0_addr(addr_s[0]),
        .p0_wdata(wdata_s[0]), .p0_read(rd_s[0]), .p0_write(wr_s[0]),
        .p0_resp_valid(rv_s[0]), .p0_rdata(rdat_s[0]), .p0_resp_err(rerr_s[0]),
        .p1_req_valid(valid_s[1]), .p1_req_ready(rdy_s[1]), .p1_addr(addr_s[1]),
        .p1_wdata(wdata_s[1]), .p1_read(rd_s[1]), .p1_write(wr_s[1]),
        .p1_resp_valid(rv_s[1]), .p1_rdata(rdat_s[1]), .p1_resp_err(rerr_s[1]),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign ma = mem_addr[15:0];

    // Data memory: combinational extended read
    always_comb begin
        case (mem_read)
            3'd1: mem_rdata = {{24{dmem[ma][7]}}, dmem[ma]};
            3'd2: mem_rdata = {{16{dmem[ma+16'd1][7]}}, dmem[ma+16'd1], dmem[ma]};
            3'd3: mem_rdata = {dmem[ma+16'd3], dmem[ma+16'd2], dmem[ma+16'd1], dmem[ma]};
            3'd4: mem_rdata = {24'd0, dmem[ma]};
            3'd5: mem_rdata = {16'd0, dmem[ma+16'd1], dmem[ma]};
            default: mem_rdata = 32'd0;
        endcase
    end

    // Data memory: writes on the falling edge
    always @(negedge clk) begin
        case (mem_write)
            2'd1: dmem[ma] <= mem_wdata[7:0];
            2'd2: begin
                dmem[ma]       <= mem_wdata[7:0];
                dmem[ma+16'd1] <= mem_wdata[15:8];
            end
            2'd3: begin
                dmem[ma]       <= mem_wdata[7:0];
                dmem[ma+16'd1] <= mem_wdata[15:8];
                dmem[ma+16'd2] <= mem_wdata[23:16];
                dmem[ma+16'd3] <= mem_wdata[31:24];
            end
            default: ;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] r, input logic [1:0] w);
        if (r != 3'd0) begin
            if (r == 3'd1 || r == 3'd4) return 1;
            if (r == 3'd2 || r == 3'd5) return 2;
            if (r == 3'd3) return 4;
            return 0;
        end
        if (w == 2'd1) return 1;
        if (w == 2'd2) return 2;
        if (w == 2'd3) return 4;
        return 0;
    endfunction

    function automatic bit ref_is_err(input logic [2:0] r, input logic [1:0] w, input logic [31:0] a);
        int sz;
        longint unsigned last;
        if ((r != 3'd0) == (w != 2'd0)) return 1'b1;
        sz = ref_size(r, w);
        if (sz == 0) return 1'b1;
        if ((a % 32'(sz)) != 32'd0) return 1'b1;
        last = longint'(a) + longint'(sz) - 64'd1;
        return (last >= (64'd1 << ADDR_W));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] r, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = ref_size(r, 2'd0);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[15:0]) + i]) << (8 * i));
        if ((r == 3'd1 || r == 3'd2) && v[8 * n - 1]) begin
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = ref_size(3'd0, w);
        for (int i = 0; i < n; i++) ref_mem[int'(a[15:0]) + i] = d[8 * i +: 8];
    endtask

    // One clock cycle: check outputs at the falling edge, advance the reference, step past posedge.
    task automatic cycle();
        int win;
        logic [31:0] nxt_rdata;
        bit ev;
        @(negedge clk);
        nxt_rdata = 32'd0;
        if (acc_pend) begin
            chk("mem_read",  32'(mem_read),  acc_err ? 32'd0 : 32'(acc_rd));
            chk("mem_write", 32'(mem_write), acc_err ? 32'd0 : 32'(acc_wr));
            chk("mem_addr",  mem_addr,  acc_addr);
            chk("mem_wdata", mem_wdata, acc_wdata);
            if (!acc_err && acc_rd != 3'd0) nxt_rdata = ref_load(acc_rd, acc_addr);
            if (!acc_err && acc_wr != 2'd0) ref_store(acc_wr, acc_addr, acc_wdata);
        end else begin
            chk("mem_read_idle",  32'(mem_read),  32'd0);
            chk("mem_write_idle", 32'(mem_write), 32'd0);
            chk("mem_addr_idle",  mem_addr,  32'd0);
            chk("mem_wdata_idle", mem_wdata, 32'd0);
        end
        for (int p = 0; p < 2; p++) begin
            ev = resp_pend && (resp_port == p);
            chk($sformatf("resp_valid%0d", p), 32'(rv_s[p]), 32'(ev));
            chk($sformatf("rdata%0d", p), rdat_s[p], ev ? resp_rdata : 32'd0);
            chk($sformatf("resp_err%0d", p), 32'(rerr_s[p]), ev ? 32'(resp_err) : 32'd0);
            if (rv_s[p]) begin
                obs_rdata[p] = rdat_s[p];
                obs_err[p]   = rerr_s[p];
            end
        end
        win = -1;
        if (!acc_pend) begin
            if (valid_s[0] && valid_s[1]) win = 1 - last_grant;
            else if (valid_s[0]) win = 0;
            else if (valid_s[1]) win = 1;
        end
        chk("ready0", 32'(rdy_s[0]), 32'(win == 0));
        chk("ready1", 32'(rdy_s[1]), 32'(win == 1));
        if (rdy_s[0] && valid_s[0]) obs_grants.push_back(0);
        else if (rdy_s[1] && valid_s[1]) obs_grants.push_back(1);
        resp_pend  = acc_pend;
        resp_port  = acc_port;
        resp_rdata = nxt_rdata;
        resp_err   = acc_err;
        acc_pend   = (win >= 0);
        if (win >= 0) begin
            last_grant = win;
            acc_port   = win;
            acc_rd     = rd_s[win];
            acc_wr     = wr_s[win];
            acc_addr   = addr_s[win];
            acc_wdata  = wdata_s[win];
            acc_err    = ref_is_err(rd_s[win], wr_s[win], addr_s[win]);
        end
        @(posedge clk);
        #1;
        if (win >= 0) valid_s[win] = 1'b0;
    endtask

    // Issue one request on port p and wait for acceptance (bounded), optionally its response.
    task automatic send(input int p, input logic [2:0] r, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d, input bit drain);
        rd_s[p] = r; wr_s[p] = w; addr_s[p] = a; wdata_s[p] = d; valid_s[p] = 1'b1;
        obs_rdata[p] = 32'hBAD0BAD0;
        obs_err[p]   = 1'bx;
        for (int i = 0; i < 8 && valid_s[p]; i++) cycle();
        if (valid_s[p]) begin
            chk("accept_timeout", 32'(valid_s[p]), 32'd0);
            valid_s[p] = 1'b0;
        end
        if (drain) begin
            cycle();
            cycle();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   32'(rdy_s),  32'd0);
        chk({tag, "_rv"},    32'(rv_s),   32'd0);
        chk({tag, "_rerr"},  32'(rerr_s), 32'd0);
        chk({tag, "_rd0"},   rdat_s[0],   32'd0);
        chk({tag, "_rd1"},   rdat_s[1],   32'd0);
        chk({tag, "_mrd"},   32'(mem_read),  32'd0);
        chk({tag, "_mwr"},   32'(mem_write), 32'd0);
        chk({tag, "_maddr"}, mem_addr,  32'd0);
        chk({tag, "_mwd"},   mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        acc_pend = 1'b0; resp_pend = 1'b0; last_grant = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k [2];
        int kind;
        for (int p = 0; p < 2; p++) begin
            addr_s[p] = 32'd0; wdata_s[p] = 32'd0; rd_s[p] = 3'd0; wr_s[p] = 2'd0;
        end
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycle();

        // Store then load round trip
        send(0, 3'd0, 2'd3, 32'h10, 32'hDEADBEEF, 1'b1);
        chk("sw_rdata", obs_rdata[0], 32'd0);
        chk("sw_err", 32'(obs_err[0]), 32'd0);
        send(0, 3'd3, 2'd0, 32'h10, 32'd0, 1'b1);
        chk("lw_rdata", obs_rdata[0], 32'hDEADBEEF);
        chk("lw_err", 32'(obs_err[0]), 32'd0);

        // Both ports streaming LBU, grants must alternate from port 0
        do_reset();
        obs_grants.delete();
        k[0] = 0; k[1] = 0;
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!valid_s[p] && k[p] < 2) begin
                    rd_s[p] = 3'd4; wr_s[p] = 2'd0; addr_s[p] = 32'h10 + 32'(p) + 32'(2 * k[p]);
                    valid_s[p] = 1'b1;
                    k[p]++;
                end
            end
            cycle();
        end
        chk("grant_count", 32'(obs_grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_grants.size(); i++)
            chk($sformatf("grant%0d", i), 32'(obs_grants[i]), 32'(i % 2));
        chk("lbu_p0_last", obs_rdata[0], 32'h000000AD);
        chk("lbu_p1_last", obs_rdata[1], 32'h000000DE);

        // Misaligned halfword on port 1
        send(1, 3'd2, 2'd0, 32'h11, 32'd0, 1'b1);
        chk("lh_mis_err", 32'(obs_err[1]), 32'd1);
        chk("lh_mis_rdata", obs_rdata[1], 32'd0);

        // Top-of-memory boundary
        send(0, 3'd0, 2'd3, 32'hFFFC, 32'hCAFEF00D, 1'b1);
        send(0, 3'd0, 2'd3, 32'hFFFE, 32'h11111111, 1'b1);
        chk("sw_top_err", 32'(obs_err[0]), 32'd1);
        send(0, 3'd1, 2'd0, 32'h10000, 32'd0, 1'b1);
        chk("lb_oob_err", 32'(obs_err[0]), 32'd1);
        send(0, 3'd3, 2'd0, 32'hFFFC, 32'd0, 1'b1);
        chk("lw_top_rdata", obs_rdata[0], 32'hCAFEF00D);
        chk("lw_top_err", 32'(obs_err[0]), 32'd0);

        // Both codes set, then neither
        send(0, 3'd3, 2'd3, 32'h40, 32'h1, 1'b1);
        chk("both_codes_err", 32'(obs_err[0]), 32'd1);
        send(0, 3'd0, 2'd0, 32'h40, 32'h1, 1'b1);
        chk("no_codes_err", 32'(obs_err[0]), 32'd1);

        // Reset during the first half of ACCESS of a store
        send(0, 3'd0, 2'd3, 32'h20, 32'h12345678, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        acc_pend = 1'b0; resp_pend = 1'b0; last_grant = 1;
        rd_s[1] = 3'd3; wr_s[1] = 2'd0; addr_s[1] = 32'h20; valid_s[1] = 1'b1;
        #1;
        chk_all_zero("in_reset");
        @(posedge clk); #1;
        chk_all_zero("in_reset2");
        rst_n = 1'b1;
        send(1, 3'd3, 2'd0, 32'h20, 32'd0, 1'b1);
        chk("aborted_sw_rdata", obs_rdata[1], 32'd0);

        // Randomized traffic on both ports against the reference
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!valid_s[p] && ($urandom_range(0, 2) != 0)) begin
                    kind = $urandom_range(0, 9);
                    if (kind == 0) begin
                        rd_s[p] = 3'($urandom_range(0, 7)); wr_s[p] = 2'($urandom_range(0, 3));
                    end else if (kind <= 5) begin
                        rd_s[p] = 3'($urandom_range(1, 5)); wr_s[p] = 2'd0;
                    end else begin
                        rd_s[p] = 3'd0; wr_s[p] = 2'($urandom_range(1, 3));
                    end
                    if ($urandom_range(0, 7) == 0) addr_s[p] = 32'hFFF8 + 32'($urandom_range(0, 7));
                    else addr_s[p] = 32'h100 + 32'($urandom_range(0, 31));
                    wdata_s[p] = $urandom;
                    valid_s[p] = 1'b1;
                end
            end
            cycle();
        end
        valid_s = 2'b00;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
